// File: rtl/warning_pkg.sv
// Shared types for the warning collector: FSM state encoding and the
// adjustment direction constants carried on adj_dir.
package warning_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        DECIDE = 2'd2,
        REQ    = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/warning_collector_if.sv
// Bus between the warning collector and its environment.
//   en, warning_in, sticky_clr, adj_ack   : driven by the master (environment)
//   adj_req, adj_dir, err_count, sticky_flags : driven by the slave (collector)
interface warning_collector_if #(
    parameter int unsigned N_MON = 8,
    parameter int unsigned CNT_W = 16
);
    logic             en;
    logic [N_MON-1:0] warning_in;
    logic             sticky_clr;
    logic             adj_ack;
    logic             adj_req;
    logic             adj_dir;
    logic [CNT_W-1:0] err_count;
    logic [N_MON-1:0] sticky_flags;

    modport master (
        output en, warning_in, sticky_clr, adj_ack,
        input  adj_req, adj_dir, err_count, sticky_flags
    );

    modport slave (
        input  en, warning_in, sticky_clr, adj_ack,
        output adj_req, adj_dir, err_count, sticky_flags
    );
endinterface

// File: rtl/warn_sync.sv
// N-bit two-flop synchronizer for asynchronous level inputs.
//   clk, rst_n : clock, async active-low reset
//   d_i        : asynchronous inputs
//   q_o        : synchronized outputs (2-cycle latency)
module warn_sync #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/warning_collector.sv
// Collects timing-monitor warnings, counts warning cycles per evaluation
// window and requests DVFS raise/lower adjustments over a req/ack handshake.
// Also keeps per-monitor sticky flags for debug.
//   clk, rst_n : system clock, async active-low reset
//   bus        : slave side of warning_collector_if (en, warning_in,
//                sticky_clr, adj_ack in; adj_req, adj_dir, err_count,
//                sticky_flags out, all registered)
module warning_collector
    import warning_pkg::*;
#(
    parameter int unsigned N_MON      = 8,
    parameter int unsigned WIN_CYCLES = 1024,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned HI_TH      = 16,
    parameter int unsigned LO_TH      = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    warning_collector_if.slave bus
);

    localparam int unsigned      WIN_W    = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);

    state_t             state_q, state_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic               adj_req_q, adj_req_d;
    logic               adj_dir_q, adj_dir_d;
    logic [N_MON-1:0]   sticky_q, sticky_d;
    logic [N_MON-1:0]   w_sync;
    logic               any_w;
    logic               win_last;
    logic               hit_hi;
    logic               hit_lo;

    warn_sync #(.W(N_MON)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (bus.warning_in),
        .q_o   (w_sync)
    );

    // Simultaneous monitors collapse into a single error cycle
    assign any_w    = |w_sync;
    assign win_last = (win_q == WIN_LAST);
    // Thresholds compared at 32 bits so they stay correct when they exceed
    // the counter range
    assign hit_hi   = (32'(cnt_q) >= HI_TH);
    assign hit_lo   = (32'(cnt_q) <= LO_TH);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.en) state_d = COUNT;
            end
            COUNT: begin
                if (!bus.en)       state_d = IDLE;
                else if (win_last) state_d = DECIDE;
            end
            DECIDE: begin
                if (!bus.en)               state_d = IDLE;
                else if (hit_hi || hit_lo) state_d = REQ;
                else                       state_d = COUNT;
            end
            REQ: begin
                // Request holds regardless of en until acknowledged
                if (bus.adj_ack) state_d = bus.en ? COUNT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        win_d       = '0;
        cnt_d       = '0;
        err_count_d = err_count_q;
        adj_dir_d   = adj_dir_q;
        adj_req_d   = (state_d == REQ);
        // A set coinciding with a clear wins
        sticky_d    = (sticky_q & ~{N_MON{bus.sticky_clr}}) | w_sync;

        case (state_q)
            COUNT: begin
                if (bus.en) begin
                    win_d = win_last ? '0 : win_q + WIN_W'(1);
                    if (any_w && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
                    else                                   cnt_d = cnt_q;
                end
            end
            DECIDE: begin
                if (bus.en) begin
                    err_count_d = cnt_q;
                    if (hit_hi)      adj_dir_d = DIR_UP;
                    else if (hit_lo) adj_dir_d = DIR_DOWN;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q       <= '0;
            cnt_q       <= '0;
            err_count_q <= '0;
            adj_req_q   <= 1'b0;
            adj_dir_q   <= 1'b0;
            sticky_q    <= '0;
        end else begin
            win_q       <= win_d;
            cnt_q       <= cnt_d;
            err_count_q <= err_count_d;
            adj_req_q   <= adj_req_d;
            adj_dir_q   <= adj_dir_d;
            sticky_q    <= sticky_d;
        end
    end

    assign bus.adj_req      = adj_req_q;
    assign bus.adj_dir      = adj_dir_q;
    assign bus.err_count    = err_count_q;
    assign bus.sticky_flags = sticky_q;

endmodule

// File: tb/tb_warning_collector.sv
// Directed bench for warning_collector: window scenarios from a vector table
// plus hand-written sequences for handshake timing, abort, sticky collision,
// saturation and asynchronous reset.
module tb_warning_collector;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    warning_collector_if #(.N_MON(4), .CNT_W(16)) bus ();
    warning_collector_if #(.N_MON(4), .CNT_W(2))  bus2 ();

    warning_collector #(
        .N_MON(4), .WIN_CYCLES(16), .CNT_W(16), .HI_TH(4), .LO_TH(0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    warning_collector #(
        .N_MON(4), .WIN_CYCLES(16), .CNT_W(2), .HI_TH(3), .LO_TH(0)
    ) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ma;
        logic [3:0]  ba;
        logic [15:0] mb;
        logic [3:0]  bb;
        logic [15:0] exp_cnt;
        logic        exp_req;
        logic        exp_dir;
        logic [3:0]  exp_sticky;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] wv(input logic [15:0] ma, input logic [3:0] ba,
                                      input logic [15:0] mb, input logic [3:0] bb,
                                      input int i);
        wv = (ma[4'(i)] ? ba : 4'h0) | (mb[4'(i)] ? bb : 4'h0);
    endfunction

    // From IDLE: one full window, warnings for window cycle i taken from the
    // masks. Returns just after the edge ending DECIDE.
    task automatic run_window(input logic [15:0] ma, input logic [3:0] ba,
                              input logic [15:0] mb, input logic [3:0] bb);
        bus.en         = 1'b0;
        bus.warning_in = wv(ma, ba, mb, bb, 0);
        tick();
        for (int i = 1; i < 16; i++) begin
            bus.en         = 1'b1;
            bus.warning_in = wv(ma, ba, mb, bb, i);
            tick();
        end
        bus.warning_in = 4'h0;
        repeat (3) tick();
    endtask

    // Return to IDLE (acking a pending request) and clear sticky flags
    task automatic go_idle(input logic had_req);
        bus.en = 1'b0;
        if (had_req) bus.adj_ack = 1'b1;
        tick();
        bus.adj_ack = 1'b0;
        check("idle_req", 32'(bus.adj_req), 32'd0);
        bus.sticky_clr = 1'b1;
        tick();
        bus.sticky_clr = 1'b0;
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        //                ma        ba       mb        bb       cnt  req   dir   sticky
        vecs[0] = '{16'h0000, 4'b0000, 16'h0000, 4'b0000, 16'd0, 1'b1, 1'b0, 4'b0000};
        vecs[1] = '{16'h00AA, 4'b0010, 16'h0200, 4'b1001, 16'd5, 1'b1, 1'b1, 4'b1011};
        vecs[2] = '{16'h0410, 4'b0100, 16'h0000, 4'b0000, 16'd2, 1'b0, 1'b0, 4'b0100};
        vecs[3] = '{16'h8105, 4'b1000, 16'h0000, 4'b0000, 16'd4, 1'b1, 1'b1, 4'b1000};
        vecs[4] = '{16'h8000, 4'b0001, 16'h0000, 4'b0000, 16'd1, 1'b0, 1'b0, 4'b0001};
        vecs[5] = '{16'h00F0, 4'b0001, 16'h0060, 4'b0010, 16'd4, 1'b1, 1'b1, 4'b0011};
        vecs[6] = '{16'h8101, 4'b0100, 16'h0000, 4'b0000, 16'd3, 1'b0, 1'b0, 4'b0100};

        rst_n           = 1'b0;
        bus.en          = 1'b0;
        bus.warning_in  = 4'h0;
        bus.sticky_clr  = 1'b0;
        bus.adj_ack     = 1'b0;
        bus2.en         = 1'b0;
        bus2.warning_in = 4'h0;
        bus2.sticky_clr = 1'b0;
        bus2.adj_ack    = 1'b0;

        // Reset and idle behaviour
        repeat (3) tick();
        check("rst_req",    32'(bus.adj_req),      32'd0);
        check("rst_dir",    32'(bus.adj_dir),      32'd0);
        check("rst_cnt",    32'(bus.err_count),    32'd0);
        check("rst_sticky", 32'(bus.sticky_flags), 32'd0);
        check("rst_cnt2",   32'(bus2.err_count),   32'd0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_req", 32'(bus.adj_req),   32'd0);
        check("idle_cnt", 32'(bus.err_count), 32'd0);
        bus.warning_in = 4'b0100;
        tick();
        bus.warning_in = 4'h0;
        tick();
        check("sticky_e2", 32'(bus.sticky_flags), 32'd0);
        tick();
        check("sticky_e3", 32'(bus.sticky_flags), 32'b0100);

        // Quiet window, ack three cycles after request
        run_window(16'h0, 4'h0, 16'h0, 4'h0);
        check("quiet_cnt", 32'(bus.err_count), 32'd0);
        check("quiet_req", 32'(bus.adj_req),   32'd1);
        check("quiet_dir", 32'(bus.adj_dir),   32'd0);
        tick();
        check("quiet_hold1", 32'(bus.adj_req), 32'd1);
        tick();
        check("quiet_hold2", 32'(bus.adj_req), 32'd1);
        bus.adj_ack = 1'b1;
        tick();
        bus.adj_ack = 1'b0;
        check("quiet_drop", 32'(bus.adj_req), 32'd0);
        // The next window began on the ack cycle; its decision lands 17 edges later
        repeat (16) tick();
        check("quiet_next_early", 32'(bus.adj_req), 32'd0);
        tick();
        check("quiet_next_req", 32'(bus.adj_req), 32'd1);
        go_idle(1'b1);

        // Table-driven windows
        for (int k = 0; k < 7; k++) begin
            run_window(vecs[k].ma, vecs[k].ba, vecs[k].mb, vecs[k].bb);
            check($sformatf("v%0d_cnt", k),    32'(bus.err_count),    32'(vecs[k].exp_cnt));
            check($sformatf("v%0d_req", k),    32'(bus.adj_req),      32'(vecs[k].exp_req));
            if (vecs[k].exp_req)
                check($sformatf("v%0d_dir", k), 32'(bus.adj_dir),     32'(vecs[k].exp_dir));
            check($sformatf("v%0d_sticky", k), 32'(bus.sticky_flags), 32'(vecs[k].exp_sticky));
            go_idle(vecs[k].exp_req);
        end

        // Mid band: next window starts right after DECIDE, no request
        run_window(16'h0410, 4'b0100, 16'h0, 4'h0);
        check("mid_cnt", 32'(bus.err_count), 32'd2);
        check("mid_req", 32'(bus.adj_req),   32'd0);
        bus.warning_in = 4'b0001;
        tick();
        check("mid_req_b", 32'(bus.adj_req), 32'd0);
        tick();
        bus.warning_in = 4'h0;
        repeat (11) tick();
        bus.warning_in = 4'b0001;
        tick();
        bus.warning_in = 4'h0;
        repeat (2) tick();
        check("mid2_early", 32'(bus.err_count), 32'd2);
        tick();
        check("mid2_cnt", 32'(bus.err_count), 32'd3);
        check("mid2_req", 32'(bus.adj_req),   32'd0);
        go_idle(1'b0);

        // Sticky set and clear on the same cycle: set wins, others clear
        bus.warning_in = 4'b1000;
        tick();
        bus.warning_in = 4'h0;
        repeat (2) tick();
        check("coll_pre", 32'(bus.sticky_flags), 32'b1000);
        bus.warning_in = 4'b0010;
        repeat (2) tick();
        bus.sticky_clr = 1'b1;
        tick();
        bus.sticky_clr = 1'b0;
        bus.warning_in = 4'h0;
        check("coll_clr", 32'(bus.sticky_flags), 32'b0010);
        tick();
        check("coll_keep", 32'(bus.sticky_flags), 32'b0010);

        // Abort at window cycle 8: partial window discarded
        for (int i = 0; i < 9; i++) begin
            bus.en         = 1'b1;
            bus.warning_in = (i < 5) ? 4'b0001 : 4'b0000;
            tick();
        end
        bus.en         = 1'b0;
        bus.warning_in = 4'h0;
        repeat (20) tick();
        check("abort_cnt", 32'(bus.err_count), 32'd3);
        check("abort_req", 32'(bus.adj_req),   32'd0);
        run_window(16'h0008, 4'b0001, 16'h0, 4'h0);
        check("fresh_cnt", 32'(bus.err_count), 32'd1);
        go_idle(1'b0);

        // en dropped during REQ: request holds until ack, then IDLE
        run_window(16'hFFFF, 4'b0100, 16'h0, 4'h0);
        check("hold_cnt", 32'(bus.err_count), 32'd16);
        check("hold_req", 32'(bus.adj_req),   32'd1);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_req_%0d", i), 32'(bus.adj_req), 32'd1);
            check($sformatf("hold_dir_%0d", i), 32'(bus.adj_dir), 32'd1);
        end
        bus.adj_ack = 1'b1;
        tick();
        bus.adj_ack = 1'b0;
        check("hold_drop", 32'(bus.adj_req), 32'd0);
        repeat (20) tick();
        check("hold_idle_req", 32'(bus.adj_req),   32'd0);
        check("hold_idle_cnt", 32'(bus.err_count), 32'd16);

        // Saturation at CNT_W=2, then async reset while requesting
        bus2.warning_in = 4'hF;
        tick();
        bus2.en = 1'b1;
        repeat (18) tick();
        check("sat_cnt", 32'(bus2.err_count), 32'd3);
        check("sat_req", 32'(bus2.adj_req),   32'd1);
        check("sat_dir", 32'(bus2.adj_dir),   32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req",    32'(bus2.adj_req),      32'd0);
        check("arst_cnt",    32'(bus2.err_count),    32'd0);
        check("arst_sticky", 32'(bus2.sticky_flags), 32'd0);
        check("arst_cnt1",   32'(bus.err_count),     32'd0);
        bus2.en         = 1'b0;
        bus2.warning_in = 4'h0;
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
